ps2_key_decoder: RTL
====================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive equal samples before the filtered PS2_CLK level changes.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000: idle CLK cycles mid-frame before the frame is abandoned (1 ms at 100 MHz).
REQ-003 CLK  in  1  system clock; all logic on its rising edge.
REQ-004 RESET  in  1  reset, asynchronous, active-high.
REQ-005 PS2_CLK  in  1  keyboard clock, asynchronous to CLK.
REQ-006 PS2_DATA  in  1  keyboard data, asynchronous to CLK.
REQ-007 KEY_VALUE  out  3  key code: 1 left, 2 up, 3 right, 4 down, 5 space; 0 only after reset.
REQ-008 KEY_VALID  out  1  one-cycle strobe marking a new KEY_VALUE; this is the game controller's key input.

Function
REQ-009 PS2_CLK and PS2_DATA SHALL each pass a 2-flop synchronizer before use.
REQ-010 The filtered clock SHALL change level only after FILTER_LEN consecutive synchronized samples at the new level; shorter glitches are ignored.
REQ-011 A 1-to-0 transition of the filtered clock SHALL sample synchronized PS2_DATA as one frame bit.
REQ-012 Frame SHALL be 11 bits: start (0), 8 data bits LSB first, odd parity, stop (1); a bit counter 0..10 tracks position.
REQ-013 Start=1, wrong parity or stop=0 SHALL discard the byte, clear the prefix state (REQ-017) and return the counter to 0.
REQ-014 If bit counter is nonzero and no sampling edge occurs for TIMEOUT_CYCLES, the counter SHALL return to 0 and any partial byte is dropped; the prefix state is kept.
REQ-015 A valid byte SHALL be presented to the byte decoder in the cycle after the stop bit is sampled.
REQ-016 Byte decoder states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 then F0).
REQ-017 Transitions: IDLE-E0->EXT; IDLE-F0->BRK; EXT-F0->EXT_BRK; any other byte in any state is decoded and the state returns to IDLE.
REQ-018 Mapping, make codes only: EXT+6B->1, EXT+75->2, EXT+74->3, EXT+72->4, IDLE+29->5.
REQ-019 All other bytes, including non-extended 6B/75/74/72 (keypad) and extended 29, SHALL produce no strobe.
REQ-020 Break sequences (F0 xx, E0 F0 xx) SHALL be consumed silently.
REQ-021 Typematic repeat make codes SHALL each produce a strobe.
REQ-022 On a mapped make code, KEY_VALUE SHALL be loaded and KEY_VALID high for exactly one cycle, 1 cycle after the byte is presented (REQ-015).
REQ-023 KEY_VALUE SHALL hold its last value between strobes.
REQ-024 Strobes are spaced by at least one full PS/2 frame; no queuing is required.

Reset
REQ-025 RESET SHALL force, asynchronously: KEY_VALUE=0, KEY_VALID=0, bit counter=0, shift register=0, timeout counter=0, decoder state IDLE, filter counter=0, filtered clock=1, synchronizer flops=1.
REQ-026 Reset mid-frame or mid-prefix SHALL lose the partial frame and prefix; decoding resumes at the next start bit after release.

Structure
REQ-027 Package ps2_pkg SHALL hold the scancode constants (E0, F0, 6B, 75, 74, 72, 29), the KEY_* codes 1..5 and the decoder state encoding.
REQ-028 Sub-module ps2_rx_frame SHALL contain synchronizers, filter, bit counter, timeout and parity check, and output byte + byte_valid + frame_error.
REQ-029 The top level SHALL contain the byte decoder FSM and the output registers only.

Verification (PS/2 clock 12.5 kHz model, CLK 100 MHz)
REQ-030 Frame 0x29 -> exactly one KEY_VALID pulse, KEY_VALUE=5 held afterwards.
REQ-031 E0 75 then E0 F0 75 -> one pulse with KEY_VALUE=2, no pulse for the break.
REQ-032 0x29 with flipped parity, then E0 6B -> no pulse for the first, one pulse with KEY_VALUE=1.
REQ-033 5 bits of a frame, idle 1.2 ms, then full 0x29 -> one pulse, KEY_VALUE=5.
REQ-034 E0, RESET pulse, 74, then E0 74 -> no pulse for the lone 74, one pulse with KEY_VALUE=3.
REQ-035 PS2_CLK low glitches of 5 CLK cycles inside a 0x72 frame after E0 -> one pulse, KEY_VALUE=4, no bit slip.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared scancodes, key codes and byte-decoder state encoding for the PS/2 key decoder.
package ps2_pkg;

    localparam int unsigned KEY_W      = 3;
    localparam int unsigned BIT_W      = 4;
    localparam int unsigned FRAME_LAST = 10;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_SPACE = 8'h29;

    localparam logic [KEY_W-1:0] KEY_NONE  = 3'd0;
    localparam logic [KEY_W-1:0] KEY_LEFT  = 3'd1;
    localparam logic [KEY_W-1:0] KEY_UP    = 3'd2;
    localparam logic [KEY_W-1:0] KEY_RIGHT = 3'd3;
    localparam logic [KEY_W-1:0] KEY_DOWN  = 3'd4;
    localparam logic [KEY_W-1:0] KEY_SPACE = 3'd5;

    typedef enum logic [1:0] {
        DEC_IDLE    = 2'd0,
        DEC_EXT     = 2'd1,
        DEC_BRK     = 2'd2,
        DEC_EXT_BRK = 2'd3
    } dec_state_e;

    // Arrows only exist as extended codes; space only as a plain code.
    function automatic logic [KEY_W-1:0] map_key(input logic ext, input logic [7:0] code);
        logic [KEY_W-1:0] key;
        key = KEY_NONE;
        if (ext) begin
            case (code)
                SC_LEFT:  key = KEY_LEFT;
                SC_UP:    key = KEY_UP;
                SC_RIGHT: key = KEY_RIGHT;
                SC_DOWN:  key = KEY_DOWN;
                default:  key = KEY_NONE;
            endcase
        end else if (code == SC_SPACE) begin
            key = KEY_SPACE;
        end
        return key;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizers, clock glitch filter, 11-bit framing,
// mid-frame timeout and parity/start/stop checking.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_error_o
);

    localparam int unsigned FILT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]        clk_sync_q, data_sync_q;
    logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
    logic              filt_clk_q, filt_clk_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [9:0]        shift_q, shift_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [7:0]        byte_q, byte_d;
    logic              byte_valid_q, byte_valid_d;
    logic              frame_error_q, frame_error_d;
    logic              fall_c, data_c, frame_ok_c;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_sync_q    <= 2'b11;
            data_sync_q   <= 2'b11;
            filt_cnt_q    <= '0;
            filt_clk_q    <= 1'b1;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            to_cnt_q      <= '0;
            byte_q        <= '0;
            byte_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            clk_sync_q    <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q   <= {data_sync_q[0], ps2_data_i};
            filt_cnt_q    <= filt_cnt_d;
            filt_clk_q    <= filt_clk_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            to_cnt_q      <= to_cnt_d;
            byte_q        <= byte_d;
            byte_valid_q  <= byte_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    // Filtered clock follows the pin only after FILTER_LEN agreeing samples.
    always_comb begin
        filt_cnt_d = '0;
        filt_clk_d = filt_clk_q;
        if (clk_sync_q[1] != filt_clk_q) begin
            if (filt_cnt_q == FILT_W'(FILTER_LEN - 1)) begin
                filt_clk_d = clk_sync_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + FILT_W'(1);
            end
        end
    end

    assign fall_c     = filt_clk_q & ~filt_clk_d;
    assign data_c     = data_sync_q[1];
    // shift_q holds start at [0], data LSB-first at [8:1], parity at [9].
    assign frame_ok_c = ~shift_q[0] & data_c & (^shift_q[9:1]);

    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        to_cnt_d      = '0;
        byte_d        = byte_q;
        byte_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        if (fall_c) begin
            if (bit_cnt_q == BIT_W'(FRAME_LAST)) begin
                bit_cnt_d = '0;
                shift_d   = '0;
                if (frame_ok_c) begin
                    byte_d       = shift_q[8:1];
                    byte_valid_d = 1'b1;
                end else begin
                    frame_error_d = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                shift_d   = {data_c, shift_q[9:1]};
            end
        end else if (bit_cnt_q != '0) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                bit_cnt_d = '0;
                shift_d   = '0;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
    end

    assign byte_o        = byte_q;
    assign byte_valid_o  = byte_valid_q;
    assign frame_error_o = frame_error_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard to game-key decoder: arrow keys and space become one-cycle
// KEY_VALID strobes with the key code held on KEY_VALUE.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ps2_clk_i,
    input  logic             ps2_data_i,
    output logic [KEY_W-1:0] key_value_o,
    output logic             key_valid_o
);

    logic [7:0]       rx_byte;
    logic             rx_valid, rx_error;
    dec_state_e       state_q, state_d;
    logic [KEY_W-1:0] key_value_q, key_value_d;
    logic             key_valid_q, key_valid_d;
    logic [KEY_W-1:0] key_c;
    logic             decode_c;

    ps2_rx_frame #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .ps2_clk_i     (ps2_clk_i),
        .ps2_data_i    (ps2_data_i),
        .byte_o        (rx_byte),
        .byte_valid_o  (rx_valid),
        .frame_error_o (rx_error)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= DEC_IDLE;
            key_value_q <= KEY_NONE;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_value_q <= key_value_d;
            key_valid_q <= key_valid_d;
        end
    end

    // Prefix tracking; break codes land in BRK/EXT_BRK and are dropped.
    always_comb begin
        state_d     = state_q;
        key_value_d = key_value_q;
        key_valid_d = 1'b0;
        decode_c    = 1'b0;
        key_c       = map_key(state_q == DEC_EXT, rx_byte);
        if (rx_error) begin
            state_d = DEC_IDLE;
        end else if (rx_valid) begin
            state_d = DEC_IDLE;
            case (state_q)
                DEC_IDLE: begin
                    if (rx_byte == SC_EXT)      state_d = DEC_EXT;
                    else if (rx_byte == SC_BRK) state_d = DEC_BRK;
                    else                        decode_c = 1'b1;
                end
                DEC_EXT: begin
                    if (rx_byte == SC_BRK) state_d = DEC_EXT_BRK;
                    else                   decode_c = 1'b1;
                end
                default: state_d = DEC_IDLE;
            endcase
            if (decode_c && (key_c != KEY_NONE)) begin
                key_value_d = key_c;
                key_valid_d = 1'b1;
            end
        end
    end

    assign key_value_o = key_value_q;
    assign key_valid_o = key_valid_q;

endmodule
